// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Arbitrates two requesters onto one shared combinational ALU. The operands
//   of the winning requester are registered onto alu_a/alu_b/alu_fxn, held
//   for SETTLE cycles so the ALU output can settle, then captured into a
//   response register. The response is held until the consumer takes it.
//
// Parameters
//   SETTLE      cycles the operands are held before the result is sampled (1..15)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_a/_b/_fxn         requester operands and ALU function code
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_c/rsp_v       captured ALU result, carry, overflow
//   rsp_id                     requester that owns the held result
//   alu_a/alu_b/alu_fxn        registered operands to the shared ALU
//   alu_out/alu_c/alu_v        combinational result from the shared ALU
//   ovf_sticky/clr_sticky      sticky overflow flag and its synchronous clear
//   op_count                   completed-operation counter (wraps)

module alu_share_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [5:0] req0_a,
    input  logic [5:0] req0_b,
    input  logic [5:0] req1_a,
    input  logic [5:0] req1_b,
    input  logic [2:0] req0_fxn,
    input  logic [2:0] req1_fxn,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [5:0] rsp_data,
    output logic       rsp_c,
    output logic       rsp_v,
    output logic       rsp_id,
    output logic [5:0] alu_a,
    output logic [5:0] alu_b,
    output logic [2:0] alu_fxn,
    input  logic [5:0] alu_out,
    input  logic       alu_c,
    input  logic       alu_v,
    output logic       ovf_sticky,
    input  logic       clr_sticky,
    output logic [7:0] op_count
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic       prio_reg;    // requester that wins a tie (0 after reset)
    logic       owner_reg;   // requester whose operands are on the ALU

    logic grant_any;
    logic grant_id;
    logic accept;
    logic capture;
    logic handshake;

    always_comb begin
        grant_any = req0_valid | req1_valid;
        // Sole valid requester wins; on a tie the round-robin pointer decides.
        grant_id  = (req0_valid & req1_valid) ? prio_reg : req1_valid;
        // Gating with rst_n keeps the ready outputs low while reset is held.
        accept    = rst_n & (state_reg == S_IDLE) & grant_any;
        capture   = (state_reg == S_SETTLE) & (cnt_reg == 4'd0);
        handshake = (state_reg == S_RESP) & rsp_ready;
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept)    state_next = S_SETTLE;
            S_SETTLE: if (capture)   state_next = S_RESP;
            S_RESP:   if (handshake) state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 4'd0;
            prio_reg   <= 1'b0;
            owner_reg  <= 1'b0;
            alu_a      <= 6'd0;
            alu_b      <= 6'd0;
            alu_fxn    <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 6'd0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_id     <= 1'b0;
            ovf_sticky <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            state_reg <= state_next;

            if (accept) begin
                alu_a     <= grant_id ? req1_a   : req0_a;
                alu_b     <= grant_id ? req1_b   : req0_b;
                alu_fxn   <= grant_id ? req1_fxn : req0_fxn;
                cnt_reg   <= CNT_LOAD;
                owner_reg <= grant_id;
                prio_reg  <= ~grant_id;   // the other side wins the next tie
            end else if ((state_reg == S_SETTLE) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (capture) begin
                rsp_data  <= alu_out;
                rsp_c     <= alu_c;
                rsp_v     <= alu_v;
                rsp_id    <= owner_reg;
                rsp_valid <= 1'b1;
            end else if (handshake) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end

            // A capture with overflow takes priority over a coincident clear.
            if (capture && alu_v) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
//   Directed bench for alu_share_ctrl. A SETTLE=1 instance runs a table of
//   single-requester operations, then hand-written sequences for sticky
//   clear, cancellation, round-robin, response back-pressure and counter
//   wrap. A SETTLE=4 instance covers the longer latency and reset during
//   settling. Each instance has its own behavioural ALU.

module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, rst_n4;
    logic       req0_valid, req1_valid, v0_4;
    logic [5:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_fxn, req1_fxn;
    logic       rsp_ready, clr_sticky;

    logic       r0_rdy, r1_rdy, rsp_valid, rsp_c, rsp_v, rsp_id, ovf_sticky;
    logic [5:0] rsp_data, alu_a, alu_b, alu_out;
    logic [2:0] alu_fxn;
    logic       alu_c, alu_v;
    logic [7:0] op_count;

    logic       r0_rdy_4, r1_rdy_4, rsp_valid_4, rsp_c_4, rsp_v_4, rsp_id_4, ovf_4;
    logic [5:0] rsp_data_4, alu_a_4, alu_b_4, alu_out_4;
    logic [2:0] alu_fxn_4;
    logic       alu_c_4, alu_v_4;
    logic [7:0] op_count_4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Shared ALU model: 110 add, 111 subtract (carry = no borrow), else AND.
    function automatic logic [7:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                             input logic [2:0] f);
        logic [6:0] s;
        logic       v;
        v = 1'b0;
        case (f)
            3'b110: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[5] == b[5]) && (s[5] != a[5]);
            end
            3'b111: begin
                s = {1'b0, a} + {1'b0, ~b} + 7'd1;
                v = (a[5] != b[5]) && (s[5] != a[5]);
            end
            default: s = {1'b0, a & b};
        endcase
        return {s[6], v, s[5:0]};
    endfunction

    assign {alu_c, alu_v, alu_out}       = alu_model(alu_a, alu_b, alu_fxn);
    assign {alu_c_4, alu_v_4, alu_out_4} = alu_model(alu_a_4, alu_b_4, alu_fxn_4);

    alu_share_ctrl #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_fxn(req0_fxn), .req1_fxn(req1_fxn),
        .req0_ready(r0_rdy), .req1_ready(r1_rdy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_id(rsp_id),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fxn(alu_fxn),
        .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
        .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky), .op_count(op_count)
    );

    alu_share_ctrl #(.SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .req0_valid(v0_4), .req1_valid(1'b0),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_fxn(req0_fxn), .req1_fxn(req1_fxn),
        .req0_ready(r0_rdy_4), .req1_ready(r1_rdy_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_4), .rsp_c(rsp_c_4), .rsp_v(rsp_v_4), .rsp_id(rsp_id_4),
        .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_fxn(alu_fxn_4),
        .alu_out(alu_out_4), .alu_c(alu_c_4), .alu_v(alu_v_4),
        .ovf_sticky(ovf_4), .clr_sticky(clr_sticky), .op_count(op_count_4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       who;
        logic [5:0] a;
        logic [5:0] b;
        logic [2:0] fxn;
        logic [5:0] data;
        logic       c;
        logic       v;
        logic       sticky;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int seen;
        int highs;

        vecs[0] = '{1'b0, 6'b001100, 6'b000001, 3'b110, 6'b001101, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'b011111, 6'b000001, 3'b110, 6'b100000, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 6'b101111, 6'b101010, 3'b111, 6'b000101, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 6'b111111, 6'b000001, 3'b110, 6'b000000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 6'b100000, 6'b000001, 3'b111, 6'b011111, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 6'b110011, 6'b101010, 3'b000, 6'b100010, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; rst_n4 = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; v0_4 = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_fxn = '0; req1_fxn = '0;
        rsp_ready = 1'b1; clr_sticky = 1'b0;

        // Reset state, with both requesters valid to show ready is held low.
        repeat (2) @(negedge clk);
        chk("rst_req0_ready", r0_rdy, 1'b0);
        chk("rst_req1_ready", r1_rdy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 6'd0);
        chk("rst_alu_a", alu_a, 6'd0);
        chk("rst_op_count", op_count, 8'd0);
        chk("rst_ovf_sticky", ovf_sticky, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; rst_n4 = 1'b1;

        // Table-driven single-requester operations.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vecs[i].who == 1'b0) begin
                req0_a = vecs[i].a; req0_b = vecs[i].b; req0_fxn = vecs[i].fxn; req0_valid = 1'b1;
            end else begin
                req1_a = vecs[i].a; req1_b = vecs[i].b; req1_fxn = vecs[i].fxn; req1_valid = 1'b1;
            end
            #1;
            chk("grant_ready", {r1_rdy, r0_rdy}, vecs[i].who ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("busy_ready", {r1_rdy, r0_rdy}, 2'b00);
            chk("alu_a", alu_a, vecs[i].a);
            chk("alu_b", alu_b, vecs[i].b);
            chk("alu_fxn", alu_fxn, vecs[i].fxn);
            req0_valid = 1'b0; req1_valid = 1'b0;
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("latency", lat, 1);
            chk("rsp_data", rsp_data, vecs[i].data);
            chk("rsp_c", rsp_c, vecs[i].c);
            chk("rsp_v", rsp_v, vecs[i].v);
            chk("rsp_id", rsp_id, vecs[i].who);
            @(negedge clk);
            chk("rsp_valid_drop", rsp_valid, 1'b0);
            chk("op_count", op_count, i + 1);
            chk("ovf_sticky", ovf_sticky, vecs[i].sticky);
            $display("vec %0d: id=%0d a=%b b=%b fxn=%b -> data=%b c=%b v=%b", i,
                     vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].fxn, rsp_data, rsp_c, rsp_v);
        end

        // Sticky clear pulse, then clear coincident with an overflowing capture.
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky_clear", ovf_sticky, 1'b0);
        req1_a = 6'b011111; req1_b = 6'b000001; req1_fxn = 3'b110; req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("coinc_rsp_valid", rsp_valid, 1'b1);
        chk("coinc_sticky", ovf_sticky, 1'b1);
        @(negedge clk);
        chk("coinc_op_count", op_count, 8'd7);
        $display("sticky: clear and set-wins sequence done, sticky=%b", ovf_sticky);

        // A request withdrawn before any clock edge leaves no trace.
        req0_a = 6'b000111; req0_valid = 1'b1;
        #2 req0_valid = 1'b0;
        highs = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) highs++;
        end
        chk("cancel_no_rsp", highs, 0);
        chk("cancel_alu_a", alu_a, 6'b011111);
        chk("cancel_op_count", op_count, 8'd7);
        $display("cancel: withdrawn request ignored");

        // Round-robin with both requesters continuously valid after reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_a = 6'b101111; req0_b = 6'b101010; req0_fxn = 3'b111;
        req1_a = 6'b001100; req1_b = 6'b000001; req1_fxn = 3'b110;
        req0_valid = 1'b1; req1_valid = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                chk("rr_id", rsp_id, seen % 2);
                chk("rr_data", rsp_data, (seen % 2) ? 6'b001101 : 6'b000101);
                $display("rr %0d: id=%0d data=%b", seen, rsp_id, rsp_data);
                seen++;
            end
        end
        chk("rr_count", seen, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("rr_op_count", op_count, 8'd4);

        // Back-pressure: response and operands frozen while rsp_ready is low.
        rsp_ready = 1'b0;
        req0_a = 6'b001100; req0_b = 6'b000001; req0_fxn = 3'b110; req0_valid = 1'b1;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_rsp_seen", rsp_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_data", rsp_data, 6'b001101);
            chk("hold_ready", {r1_rdy, r0_rdy}, 2'b00);
            chk("hold_alu", {alu_a, alu_b, alu_fxn}, {6'b001100, 6'b000001, 3'b110});
        end
        rsp_ready = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        chk("hold_release", rsp_valid, 1'b0);
        chk("hold_op_count", op_count, 8'd5);
        $display("hold: response held 5 cycles, data=%b", rsp_data);

        // op_count wrap after 256 completions.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 3000 && seen < 256; cyc++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        chk("wrap_responses", seen, 256);
        chk("wrap_before", op_count, 8'd255);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("wrap_after", op_count, 8'd0);
        $display("wrap: 256 operations, op_count=%0d", op_count);

        // SETTLE=4 latency.
        req0_a = 6'b000011; req0_b = 6'b000100; req0_fxn = 3'b110; v0_4 = 1'b1;
        @(negedge clk);
        v0_4 = 1'b0;
        lat = 0;
        while (rsp_valid_4 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("s4_latency", lat, 4);
        chk("s4_rsp_data", rsp_data_4, 6'b000111);
        @(negedge clk);
        chk("s4_op_count", op_count_4, 8'd1);
        $display("s4: latency=%0d data=%b", lat, rsp_data_4);

        // Asynchronous reset in the middle of settling discards the operation.
        v0_4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n4 = 1'b0;
        #1;
        chk("s4_rst_rsp_valid", rsp_valid_4, 1'b0);
        chk("s4_rst_rsp_data", rsp_data_4, 6'd0);
        chk("s4_rst_alu_a", alu_a_4, 6'd0);
        chk("s4_rst_ready", r0_rdy_4, 1'b0);
        chk("s4_rst_op_count", op_count_4, 8'd0);
        v0_4 = 1'b0;
        @(negedge clk);
        rst_n4 = 1'b1;
        highs = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid_4 === 1'b1) highs++;
        end
        chk("s4_no_rsp_after_rst", highs, 0);
        $display("s4: reset during settle, responses after release=%0d", highs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
